// File: rtl/x_mux_trigger_gen_if.sv
// x_mux_trigger_gen_if: arm/trigger/config inputs and status outputs of the trigger generator.
// o_evcnt exists only when X_MUX_TRIGGER_GEN_EVCNT_EN is defined.
interface x_mux_trigger_gen_if #(
    parameter int STAGES  = 32,
    parameter int WIDTH_W = 8
);
    logic               i_arm;
    logic               i_trigger;
    logic [STAGES-1:0]  i_data;
    logic [WIDTH_W-1:0] i_width;
    logic               o_driver;
    logic               o_armed;
    logic               o_busy;
    logic               o_done;
`ifdef X_MUX_TRIGGER_GEN_EVCNT_EN
    logic [15:0]        o_evcnt;
    modport master (
        output i_arm, i_trigger, i_data, i_width,
        input  o_driver, o_armed, o_busy, o_done, o_evcnt
    );
    modport slave (
        input  i_arm, i_trigger, i_data, i_width,
        output o_driver, o_armed, o_busy, o_done, o_evcnt
    );
`else
    modport master (
        output i_arm, i_trigger, i_data, i_width,
        input  o_driver, o_armed, o_busy, o_done
    );
    modport slave (
        input  i_arm, i_trigger, i_data, i_width,
        output o_driver, o_armed, o_busy, o_done
    );
`endif
endinterface

// File: rtl/x_mux_trigger_gen.sv
// x_mux_trigger_gen: armed edge trigger producing a len-cycle pulse through a selectable register delay chain.
// Optional completed-operation counter o_evcnt enabled by X_MUX_TRIGGER_GEN_EVCNT_EN.
module x_mux_trigger_gen #(
    parameter int STAGES  = 32,
    parameter int WIDTH_W = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    x_mux_trigger_gen_if.slave bus
);
    localparam int KW = $clog2(STAGES + 1);
    localparam int CW = (WIDTH_W > KW) ? WIDTH_W : KW;

    typedef enum logic [2:0] {IDLE, ARMED, FIRE, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [STAGES-1:0]  sel_q, sel_d, chain_q, chain_d;
    logic [WIDTH_W-1:0] len_q, len_d;
    logic [KW-1:0]      k_q, k_d, pop;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               inject_q, inject_d, trig_prev_q, trig_prev_d;
    logic               armed_q, armed_d, busy_q, busy_d, done_q, done_d;
    logic               drv;
`ifdef X_MUX_TRIGGER_GEN_EVCNT_EN
    logic [15:0]        evcnt_q, evcnt_d;
    always_comb evcnt_d = evcnt_q + 16'(state_q == DONE);
    assign bus.o_evcnt = evcnt_q;
`endif

    always_comb begin
        pop = '0;
        for (int i = 0; i < STAGES; i++) pop = pop + KW'(bus.i_data[i]);
    end

    // One shared down-counter times the pulse in FIRE and then the flush in DRAIN.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        len_d       = len_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        inject_d    = inject_q;
        trig_prev_d = bus.i_trigger;
        case (state_q)
            IDLE: if (bus.i_arm) begin
                state_d = ARMED;
                sel_d   = bus.i_data;
                len_d   = (bus.i_width == '0) ? WIDTH_W'(1) : bus.i_width;
                k_d     = pop;
            end
            ARMED: if (bus.i_trigger && !trig_prev_q) begin
                state_d  = FIRE;
                inject_d = 1'b1;
                cnt_d    = CW'(len_q) - CW'(1);
            end
            FIRE: if (cnt_q == '0) begin
                inject_d = 1'b0;
                state_d  = (k_q == '0) ? DONE : DRAIN;
                cnt_d    = CW'(k_q) - CW'(1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            DRAIN: if (cnt_q == '0) state_d = DONE;
                   else cnt_d = cnt_q - CW'(1);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        armed_d = state_d == ARMED;
        busy_d  = state_d == FIRE || state_d == DRAIN;
        done_d  = state_d == DONE;
    end

    // Every stage flop samples the previous stage; sel only chooses whether it is in the path.
    always_comb begin
        chain_d = '0;
        drv     = inject_q;
        for (int i = 0; i < STAGES; i++) begin
            chain_d[i] = drv;
            drv        = sel_q[i] ? chain_q[i] : drv;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            len_q       <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            inject_q    <= 1'b0;
            trig_prev_q <= 1'b0;
            chain_q     <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef X_MUX_TRIGGER_GEN_EVCNT_EN
            evcnt_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            len_q       <= len_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            inject_q    <= inject_d;
            trig_prev_q <= trig_prev_d;
            chain_q     <= chain_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef X_MUX_TRIGGER_GEN_EVCNT_EN
            evcnt_q     <= evcnt_d;
`endif
        end
    end

    assign bus.o_driver = drv;
    assign bus.o_armed  = armed_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
endmodule

// File: tb/tb_x_mux_trigger_gen.sv
// tb_x_mux_trigger_gen: timeline reference model checked every cycle, plus directed latency cases.
module tb_x_mux_trigger_gen;
    localparam int S = 32;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x_mux_trigger_gen_if #(.STAGES(S), .WIDTH_W(W)) bus();
    x_mux_trigger_gen #(.STAGES(S), .WIDTH_W(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Model: 0 idle, 1 armed, 2 operation fired at period m_tf; outputs follow from m_tf, m_len, m_k.
    int          m_phase = 0, m_tf = 0, m_len = 0, m_k = 0;
    logic        m_prev = 1'b0;
    logic        m_edge;
    logic [15:0] m_ev = '0;

    int   hi_cnt = 0, done_cnt = 0, rise_cyc = -1, done_cyc = -1;
    logic prev_drv = 1'b0;
    logic e_drv, e_arm, e_busy, e_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_edge = bus.i_trigger && !m_prev;
        if (rst) begin
            m_phase = 0;
            m_ev    = '0;
        end else if (m_phase == 0) begin
            if (bus.i_arm === 1'b1) begin
                m_phase = 1;
                m_len   = (bus.i_width == 0) ? 1 : int'(bus.i_width);
                m_k     = $countones(bus.i_data);
            end
        end else if (m_phase == 1) begin
            if (m_edge) begin
                m_phase = 2;
                m_tf    = cyc;
            end
        end else if (cyc == m_tf + m_len + m_k + 1) begin
            m_phase = 0;
            m_ev    = m_ev + 16'd1;
        end
        m_prev = rst ? 1'b0 : bus.i_trigger;
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            e_arm  = m_phase == 1;
            e_busy = m_phase == 2 && cyc >= m_tf + 1 && cyc <= m_tf + m_len + m_k;
            e_drv  = m_phase == 2 && cyc >= m_tf + 1 + m_k && cyc <= m_tf + m_len + m_k;
            e_done = m_phase == 2 && cyc == m_tf + m_len + m_k + 1;
            chk("o_driver", 32'(bus.o_driver), 32'(e_drv));
            chk("o_armed", 32'(bus.o_armed), 32'(e_arm));
            chk("o_busy", 32'(bus.o_busy), 32'(e_busy));
            chk("o_done", 32'(bus.o_done), 32'(e_done));
`ifdef X_MUX_TRIGGER_GEN_EVCNT_EN
            chk("o_evcnt", 32'(bus.o_evcnt), 32'(m_ev));
`endif
            if (bus.o_driver === 1'b1 && !prev_drv) rise_cyc = cyc;
            if (bus.o_driver === 1'b1) hi_cnt++;
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_drv = bus.o_driver === 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (m_phase != 0 && n < 3000) begin
            step();
            n++;
        end
        n_cmp++;
        if (m_phase != 0) begin
            n_err++;
            $display("FAIL %s_timeout: still active after %0d cycles, required idle", nm, n);
        end
    endtask

    task automatic fire_op(input logic [S-1:0] d, input logic [W-1:0] w, output int t);
        wait_idle("idle_before_op");
        bus.i_data = d; bus.i_width = w; bus.i_arm = 1'b1; bus.i_trigger = 1'b0;
        step();
        bus.i_arm = 1'b0; bus.i_trigger = 1'b1; t = cyc;
        step();
        bus.i_trigger = 1'b0;
    endtask

    task automatic measure(input string nm, input logic [S-1:0] d, input logic [W-1:0] w, input int k, input int len);
        int t, h0, d0;
        h0 = hi_cnt; d0 = done_cnt;
        fire_op(d, w, t);
        wait_idle(nm);
        chk({nm, "_rise"}, rise_cyc, t + 1 + k);
        chk({nm, "_len"}, hi_cnt - h0, len);
        chk({nm, "_ndone"}, done_cnt - d0, 1);
        chk({nm, "_done_at"}, done_cyc, t + len + k + 1);
    endtask

    initial begin
        int t, h0, d0;
        bus.i_arm = 1'b0; bus.i_trigger = 1'b0; bus.i_data = '0; bus.i_width = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_driver", 32'(bus.o_driver), 0);
        chk("rst_armed", 32'(bus.o_armed), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_done", 32'(bus.o_done), 0);

        measure("zero_delay", '0, 8'd1, 0, 1);
        measure("max_delay", '1, 8'd4, 32, 4);
        measure("width0", 32'h0000_0100, 8'd0, 1, 1);
        measure("width_max", 32'h0000_0005, 8'd255, 2, 255);

        // Trigger held high across arming must not fire.
        wait_idle("preheld");
        h0 = hi_cnt; d0 = done_cnt;
        bus.i_trigger = 1'b1;
        step();
        bus.i_data = 32'hAAAA_AAAA; bus.i_width = 8'd5; bus.i_arm = 1'b1;
        step();
        bus.i_arm = 1'b0;
        repeat (4) step();
        chk("preheld_armed", 32'(bus.o_armed), 1);
        chk("preheld_nofire", hi_cnt - h0, 0);
        bus.i_trigger = 1'b0;
        step();
        bus.i_trigger = 1'b1; t = cyc;
        step();
        bus.i_trigger = 1'b0;
        wait_idle("preheld");
        chk("preheld_rise", rise_cyc, t + 17);
        chk("preheld_len", hi_cnt - h0, 5);
        chk("preheld_done_at", done_cyc, t + 22);
        chk("preheld_ndone", done_cnt - d0, 1);

        // Arm and trigger edge in the same idle cycle: arm only.
        h0 = hi_cnt;
        bus.i_trigger = 1'b0;
        step();
        bus.i_arm = 1'b1; bus.i_trigger = 1'b1; bus.i_data = '0; bus.i_width = 8'd1;
        step();
        bus.i_arm = 1'b0;
        step(); step();
        chk("armedge_armed", 32'(bus.o_armed), 1);
        chk("armedge_nofire", hi_cnt - h0, 0);
        bus.i_trigger = 1'b0;
        step();
        bus.i_trigger = 1'b1; t = cyc;
        step();
        bus.i_trigger = 1'b0;
        wait_idle("armedge");
        chk("armedge_rise", rise_cyc, t + 1);

        // Arm pulse and new data/width during FIRE are ignored.
        h0 = hi_cnt; d0 = done_cnt;
        fire_op(32'h0000_0003, 8'd3, t);
        bus.i_arm = 1'b1; bus.i_data = '1; bus.i_width = 8'd200;
        step();
        bus.i_arm = 1'b0;
        wait_idle("ignored");
        chk("ignored_rise", rise_cyc, t + 3);
        chk("ignored_len", hi_cnt - h0, 3);
        chk("ignored_ndone", done_cnt - d0, 1);
        chk("ignored_done_at", done_cyc, t + 6);

        // Reset in the middle of DRAIN (k=4, len=2: DRAIN spans t+3..t+6).
        d0 = done_cnt;
        fire_op(32'h0000_000F, 8'd2, t);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_driver", 32'(bus.o_driver), 0);
        chk("abort_busy", 32'(bus.o_busy), 0);
        chk("abort_armed", 32'(bus.o_armed), 0);
        chk("abort_done", 32'(bus.o_done), 0);
        repeat (10) step();
        chk("abort_ndone", done_cnt - d0, 0);
        measure("after_abort", 32'h8000_0001, 8'd3, 2, 3);

`ifdef X_MUX_TRIGGER_GEN_EVCNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        measure("ev1", '0, 8'd1, 0, 1);
        measure("ev2", 32'h1, 8'd2, 1, 2);
        measure("ev3", 32'h3, 8'd1, 2, 1);
        step();
        chk("evcnt_three", 32'(bus.o_evcnt), 3);
`endif

        for (int n = 0; n < 150; n++) begin
            bus.i_trigger = 1'($urandom_range(0, 1));
            bus.i_data    = ($urandom_range(0, 9) == 0) ? S'($urandom) : S'($urandom & $urandom & $urandom);
            bus.i_width   = W'($urandom_range(0, 20));
            bus.i_arm     = 1'b1;
            step();
            bus.i_arm = 1'b0;
            for (int j = 0; j < 300 && m_phase != 0; j++) begin
                bus.i_arm     = ($urandom_range(0, 3) == 0);
                bus.i_data    = S'($urandom);
                bus.i_width   = W'($urandom);
                bus.i_trigger = 1'($urandom_range(0, 1));
                rst           = ($urandom_range(0, 149) == 0);
                step();
                rst = 1'b0;
            end
            bus.i_arm = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/x_mux_trigger_gen.md
X_MUX_TRIGGER_GEN -- requirements
Module: x_mux_trigger_gen

Interface
REQ-001 Parameter STAGES, default 32, sets the number of mux delay stages and the width of i_data; legal range 1..64.
REQ-002 Parameter WIDTH_W, default 8, sets the width of the pulse-length input.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  is the sole clock; all flops update on its rising edge.
REQ-005 i_rst  input  1  is the synchronous active-high reset.
REQ-006 i_arm  input  1  requests arming and is sampled only in IDLE.
REQ-007 i_trigger  input  1  is the synchronous trigger level; its rising edge fires the block.
REQ-008 i_data  input  STAGES  is the per-stage delay select (bit i=1 inserts one register in stage i).
REQ-009 i_width  input  WIDTH_W  is the output pulse length in cycles (0 is treated as 1).
REQ-010 o_driver  output  1  is the delayed trigger pulse, taken from the last chain stage.
REQ-011 o_armed  output  1  is high while the FSM is in ARMED.
REQ-012 o_busy  output  1  is high in FIRE and DRAIN.
REQ-013 o_done  output  1  is a one-cycle pulse on completion.

Function
REQ-014 The FSM states SHALL be IDLE, ARMED, FIRE, DRAIN and DONE.
REQ-015 IDLE->ARMED when i_arm=1, capturing sel<=i_data, len<=max(i_width,1) and k<=popcount(i_data).
REQ-016 ARMED->FIRE when i_trigger=1 and the registered previous i_trigger=0; a level held high since before arming SHALL NOT fire.
REQ-017 In FIRE, the inject register SHALL be 1 for exactly len cycles, starting the cycle after the edge is sampled; then FIRE->DRAIN.
REQ-018 DRAIN SHALL last k cycles (0 cycles if k=0, i.e. straight to DONE); DRAIN->DONE.
REQ-019 DONE SHALL last one cycle with o_done=1, then DONE->IDLE.
REQ-020 Chain stage i SHALL be defined as out_i = sel[i] ? flop_i(out_(i-1)) : out_(i-1), with out_(-1) = the inject register and o_driver = out_(STAGES-1).
REQ-021 Latency: for an edge sampled at cycle t, o_driver SHALL be high for cycles t+1+k through t+len+k inclusive, and o_done SHALL be high at cycle t+len+k+1.
REQ-022 i_arm outside IDLE, and i_trigger edges outside ARMED, SHALL be ignored.
REQ-023 Changes to i_data and i_width after arming SHALL NOT affect the operation in progress.
REQ-024 Simultaneous i_arm and a trigger edge in IDLE SHALL arm only; the edge SHALL NOT fire.
REQ-025 i_width at its all-ones value SHALL produce a pulse of 2^WIDTH_W-1 cycles, with no counter wrap.

Reset
REQ-026 i_rst=1 SHALL force the FSM to IDLE and clear sel, len, k, the inject register, all chain flops and the previous-trigger register.
REQ-027 During and after reset, o_driver, o_armed, o_busy and o_done SHALL all be 0.
REQ-028 Reset asserted mid-FIRE or mid-DRAIN SHALL abort the operation: o_driver is 0 from the next cycle, and no o_done is produced.

Configuration
REQ-029 With macro X_MUX_TRIGGER_GEN_EVCNT_EN defined, the block SHALL add output o_evcnt (16 bits), which counts completed DONE events, wraps 0xFFFF->0 and is cleared by i_rst.
REQ-030 Without X_MUX_TRIGGER_GEN_EVCNT_EN, the port o_evcnt and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-031 Zero-delay case: i_data=0, i_width=1, arm, trigger edge sampled at t -> o_driver high at t+1 only; o_done at t+2.
REQ-032 Maximum delay and width: i_data=0xFFFFFFFF, i_width=4, edge at t -> o_driver high for t+33..t+36; o_done at t+37.
REQ-033 Pre-held trigger: i_data=0xAAAAAAAA, i_trigger held high before arming -> no fire; after a 0 then 1 on i_trigger (edge at t) -> o_driver high for t+17..t+16+len.
REQ-034 Reset abort: i_rst asserted in the middle of DRAIN -> all outputs 0 the next cycle, no o_done, FSM in IDLE.
REQ-035 Ignored inputs: i_arm pulsed and i_data changed during FIRE -> timing unchanged from the originally captured values; a single o_done.
REQ-036 With X_MUX_TRIGGER_GEN_EVCNT_EN defined: 3 complete operations -> o_evcnt=3; counter preset to 0xFFFF and one operation completed -> o_evcnt=0.
